// File: rtl/vga_text_renderer.sv
// Text-mode pixel generator: 80x30 characters of 8x16 glyphs with a blinking underline cursor.
// Five-stage fetch pipeline (VRAM address, VRAM data, font address, font data, pixel), syncs delayed to match.
module vga_text_renderer #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BLINK_BIT = 5
) (
    input  logic        PIXEL_CLOCK,
    input  logic        RESET,
    input  logic [9:0]  SCREEN_X,
    input  logic [9:0]  SCREEN_Y,
    input  logic        ON_SCREEN,
    input  logic        Hs,
    input  logic        Vs,
    output logic [11:0] VRAM_ADDR,
    input  logic [7:0]  VRAM_DATA,
    output logic [11:0] FONT_ADDR,
    input  logic [7:0]  FONT_DATA,
    input  logic        CURSOR_EN,
    input  logic [6:0]  CURSOR_COL,
    input  logic [4:0]  CURSOR_ROW,
    output logic        PIXEL_OUT,
    output logic        HS_OUT,
    output logic        VS_OUT,
    output logic        DE_OUT
);

    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

    logic [6:0]  col;
    logic [5:0]  row;
    logic        in_view;
    logic [11:0] char_addr;
    logic        cursor_hit;

    logic [3:0][2:0] x_pipe;
    logic [1:0][3:0] y_pipe;
    logic [3:0]      hit_pipe;
    logic [3:0]      hs_pipe;
    logic [3:0]      vs_pipe;
    logic [3:0]      de_pipe;
    logic [5:0]      frame_cnt;

    assign col     = SCREEN_X[9:3];
    assign row     = SCREEN_Y[9:4];
    assign in_view = (SCREEN_X < H_LIM) && (SCREEN_Y < V_LIM);

    // row*80 as row*64 + row*16
    assign char_addr = {row, 6'b0} + {2'b0, row, 4'b0} + {5'b0, col};

    assign cursor_hit = CURSOR_EN && (col == CURSOR_COL) && (row == {1'b0, CURSOR_ROW})
                        && (SCREEN_Y[3:0] >= 4'd14);

    always_ff @(posedge PIXEL_CLOCK) begin
        if (RESET) begin
            VRAM_ADDR <= '0;
            FONT_ADDR <= '0;
            PIXEL_OUT <= 1'b0;
            x_pipe    <= '0;
            y_pipe    <= '0;
            hit_pipe  <= '0;
            hs_pipe   <= '1;
            vs_pipe   <= '1;
            de_pipe   <= '0;
            frame_cnt <= '0;
        end else begin
            VRAM_ADDR <= in_view ? char_addr : '0;
            x_pipe    <= {x_pipe[2:0], SCREEN_X[2:0]};
            y_pipe    <= {y_pipe[0], SCREEN_Y[3:0]};
            hit_pipe  <= {hit_pipe[2:0], cursor_hit};
            // sync inputs already lag the coordinates by one cycle, so four stages realign them
            hs_pipe   <= {hs_pipe[2:0], Hs};
            vs_pipe   <= {vs_pipe[2:0], Vs};
            de_pipe   <= {de_pipe[2:0], ON_SCREEN};
            FONT_ADDR <= {VRAM_DATA, y_pipe[1]};
            PIXEL_OUT <= (FONT_DATA[3'd7 - x_pipe[3]] | (hit_pipe[3] & frame_cnt[BLINK_BIT]))
                         & de_pipe[2];
            if (SCREEN_X == '0 && SCREEN_Y == '0)
                frame_cnt <= frame_cnt + 6'd1;
        end
    end

    assign HS_OUT = hs_pipe[3];
    assign VS_OUT = vs_pipe[3];
    assign DE_OUT = de_pipe[3];

endmodule

// File: tb/tb_vga_text_renderer.sv
// Bench for vga_text_renderer: directed sequences plus randomized coordinates,
// checked against a per-coordinate arithmetic model with fixed 5-cycle output latency.
module tb_vga_text_renderer;

    localparam int H_ACT = 640;
    localparam int V_ACT = 480;
    localparam int BLINK = 5;

    logic        PIXEL_CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [9:0]  SCREEN_X = '0;
    logic [9:0]  SCREEN_Y = '0;
    logic        ON_SCREEN = 1'b0;
    logic        Hs = 1'b1;
    logic        Vs = 1'b1;
    logic [11:0] VRAM_ADDR;
    logic [7:0]  VRAM_DATA;
    logic [11:0] FONT_ADDR;
    logic [7:0]  FONT_DATA;
    logic        CURSOR_EN = 1'b0;
    logic [6:0]  CURSOR_COL = '0;
    logic [4:0]  CURSOR_ROW = '0;
    logic        PIXEL_OUT;
    logic        HS_OUT;
    logic        VS_OUT;
    logic        DE_OUT;

    vga_text_renderer #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .BLINK_BIT(BLINK)) dut (
        .PIXEL_CLOCK(PIXEL_CLOCK), .RESET(RESET),
        .SCREEN_X(SCREEN_X), .SCREEN_Y(SCREEN_Y), .ON_SCREEN(ON_SCREEN),
        .Hs(Hs), .Vs(Vs),
        .VRAM_ADDR(VRAM_ADDR), .VRAM_DATA(VRAM_DATA),
        .FONT_ADDR(FONT_ADDR), .FONT_DATA(FONT_DATA),
        .CURSOR_EN(CURSOR_EN), .CURSOR_COL(CURSOR_COL), .CURSOR_ROW(CURSOR_ROW),
        .PIXEL_OUT(PIXEL_OUT), .HS_OUT(HS_OUT), .VS_OUT(VS_OUT), .DE_OUT(DE_OUT)
    );

    always #5 PIXEL_CLOCK = ~PIXEL_CLOCK;

    logic [7:0] vram [0:4095];
    logic [7:0] font [0:4095];

    // synchronous RAM/ROM: data valid the cycle after the address is sampled
    always @(posedge PIXEL_CLOCK) begin
        VRAM_DATA <= vram[VRAM_ADDR];
        FONT_DATA <= font[FONT_ADDR];
    end

    typedef struct {
        int x; int y;
        bit on; bit hs; bit vs; bit rst; bit cen;
        int ccol; int crow; int fc;
    } hist_t;

    typedef struct {
        int x; int y; int exp_addr;
    } addr_vec_t;

    hist_t hist [16];
    int    cyc = -1;
    int    n_pass = 0;
    int    n_total = 0;
    bit    cen = 0;
    int    ccol = 0;
    int    crow = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int addr_of(input int x, input int y);
        if (x < H_ACT && y < V_ACT) return (y / 16) * 80 + x / 8;
        return 0;
    endfunction

    function automatic bit pix_of(input hist_t h, input int fc);
        logic [7:0] bits;
        int ch;
        bit hit;
        if (!h.on) return 1'b0;
        ch   = int'(vram[addr_of(h.x, h.y)]);
        bits = font[ch * 16 + h.y % 16];
        hit  = h.cen && (h.x / 8 == h.ccol) && (h.y / 16 == h.crow) && (h.y % 16 >= 14);
        return bits[7 - h.x % 8] | (hit && (((fc >> BLINK) & 1) == 1));
    endfunction

    function automatic bit hs_of(input int x);
        return !(x >= 656 && x <= 751);
    endfunction

    // Outputs of cycle k belong to the coordinate presented in cycle k-5.
    task automatic check_cycle();
        hist_t h1, h2, h3, h5;
        bit rst4;
        h1 = hist[(cyc - 1) & 15];
        h2 = hist[(cyc - 2) & 15];
        h3 = hist[(cyc - 3) & 15];
        h5 = hist[(cyc - 5) & 15];
        rst4 = h1.rst | h2.rst | h3.rst | hist[(cyc - 4) & 15].rst;

        chk("vram_addr", VRAM_ADDR, h1.rst ? 0 : addr_of(h1.x, h1.y));
        if (h1.rst)
            chk("font_addr_rst", FONT_ADDR, 0);
        else if (!h2.rst && !h3.rst && h3.on)
            chk("font_addr", FONT_ADDR, int'(vram[addr_of(h3.x, h3.y)]) * 16 + h3.y % 16);

        if (rst4) begin
            chk("hs_rst", HS_OUT, 1);
            chk("vs_rst", VS_OUT, 1);
            chk("de_rst", DE_OUT, 0);
            chk("pix_rst", PIXEL_OUT, 0);
        end else begin
            chk("hs_out", HS_OUT, h5.hs);
            chk("vs_out", VS_OUT, h5.vs);
            chk("de_out", DE_OUT, h5.on);
            if (!h5.rst)
                chk("pixel", PIXEL_OUT, pix_of(h5, h2.fc));
        end
    endtask

    // One pixel clock: present (x,y) plus the previous coordinate's ON/Hs/Vs, then check at the falling edge.
    task automatic step(input int x, input int y, input bit hs, input bit vs, input bit rst);
        hist_t h, p;
        @(posedge PIXEL_CLOCK);
        #1;
        cyc++;
        p = hist[(cyc - 1) & 15];
        h.x = x; h.y = y;
        h.on = (x < H_ACT && y < V_ACT);
        h.hs = hs; h.vs = vs; h.rst = rst;
        h.cen = cen; h.ccol = ccol; h.crow = crow;
        h.fc = rst ? 0 : ((x == 0 && y == 0) ? (p.fc + 1) % 64 : p.fc);
        hist[cyc & 15] = h;
        SCREEN_X   = 10'(x);
        SCREEN_Y   = 10'(y);
        ON_SCREEN  = p.on;
        Hs         = p.hs;
        Vs         = p.vs;
        RESET      = rst;
        CURSOR_EN  = cen;
        CURSOR_COL = 7'(ccol);
        CURSOR_ROW = 5'(crow);
        #4;
        check_cycle();
    endtask

    task automatic flush();
        for (int i = 0; i < 6; i++) step(700, 500, 1, 1, 0);
    endtask

    // Scan the area around the cursor cell (col 4..6, rows 2..3) and count lit pixels.
    task automatic frame(input bit vis, input bit origin);
        int ones;
        ones = 0;
        if (origin) begin
            step(0, 0, 1, 1, 0);
            ones += int'(PIXEL_OUT);
        end
        for (int y = 45; y <= 48; y++)
            for (int x = 36; x <= 51; x++) begin
                step(x, y, 1, 1, 0);
                ones += int'(PIXEL_OUT);
            end
        for (int i = 0; i < 6; i++) begin
            step(700, 500, 1, 1, 0);
            ones += int'(PIXEL_OUT);
        end
        chk("cursor_pixels", ones, vis ? 16 : 0);
    endtask

    initial begin
        addr_vec_t tab [11];
        logic [7:0] pat;
        int c0, c8, c639, c656, first_low, n_low;
        int x, y, r;

        tab[0]  = '{639, 479, 2399};
        tab[1]  = '{8,   16,  81};
        tab[2]  = '{700, 10,  0};
        tab[3]  = '{10,  500, 0};
        tab[4]  = '{7,   15,  0};
        tab[5]  = '{640, 0,   0};
        tab[6]  = '{0,   480, 0};
        tab[7]  = '{639, 0,   79};
        tab[8]  = '{0,   479, 2320};
        tab[9]  = '{100, 200, 972};
        tab[10] = '{0,   0,   0};

        for (int i = 0; i < 16; i++) hist[i] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 4096; i++) begin
            vram[i] = '0;
            font[i] = '0;
        end
        vram[0]     = 8'h01;
        font[12'h010] = 8'h80;
        vram[81]    = 8'h41;
        font[12'h413] = 8'hA5;

        // reset held 3 cycles with sync active, released on (0,0)
        step(700, 490, 0, 0, 1);
        step(750, 491, 0, 0, 1);
        step(799, 524, 1, 1, 1);
        c0 = 0;
        for (int i = 0; i < 12; i++) begin
            step(i, 0, 1, 1, 0);
            if (i == 0) c0 = cyc;
            if (i >= 1 && i <= 4) begin
                chk("rst_align_hs", HS_OUT, 1);
                chk("rst_align_vs", VS_OUT, 1);
                chk("rst_align_de", DE_OUT, 0);
                chk("rst_align_pix", PIXEL_OUT, 0);
            end
            if (i == 5) begin
                chk("first_pix_cycle", cyc - c0, 5);
                chk("first_de", DE_OUT, 1);
                chk("first_pix", PIXEL_OUT, 1);
            end
        end
        flush();
        vram[0] = 8'h00;

        foreach (tab[i]) begin
            step(tab[i].x, tab[i].y, 1, 1, 0);
            step(700, 500, 1, 1, 0);
            chk("vram_addr_tab", VRAM_ADDR, tab[i].exp_addr);
        end

        // glyph row fetch across character (1,1)
        pat = 8'hA5;
        c8 = 0;
        for (int i = 0; i < 24; i++) begin
            step(i, 19, 1, 1, 0);
            if (i == 8) c8 = cyc;
            if (i >= 8 && cyc == c8 + 3) chk("glyph_font_addr", FONT_ADDR, 12'h413);
            if (i >= 8 && cyc >= c8 + 5 && cyc <= c8 + 12)
                chk("glyph_pixel", PIXEL_OUT, pat[7 - (cyc - c8 - 5)]);
        end

        // hsync and display-enable alignment
        first_low = -1; n_low = 0; c639 = 0; c656 = 0;
        for (int i = 0; i < 210; i++) begin
            x = (i < 200) ? 600 + i : i - 200;
            y = (i < 200) ? 10 : 11;
            step(x, y, hs_of(x), 1, 0);
            if (i < 200 && x == 639) c639 = cyc;
            if (i < 200 && x == 656) c656 = cyc;
            if (HS_OUT == 1'b0) begin
                if (first_low < 0) first_low = cyc;
                n_low++;
            end
            if (i >= 39 && cyc == c639 + 5) chk("de_last_visible", DE_OUT, 1);
            if (i >= 39 && cyc == c639 + 6) chk("de_falls", DE_OUT, 0);
        end
        chk("hs_width", n_low, 96);
        chk("hs_delay", first_low - c656, 5);

        // cursor blink over 65 frames after a fresh reset
        flush();
        step(700, 500, 1, 1, 1);
        flush();
        cen = 1; ccol = 5; crow = 2;
        frame(0, 0);
        for (int k = 1; k <= 96; k++) frame((k % 64) >= 32, 1);

        // reset in the middle of a blinking frame
        for (int i = 296; i < 300; i++) step(i, 200, 0, 0, 0);
        step(300, 200, 0, 0, 1);
        step(301, 200, 1, 1, 0);
        chk("mid_rst_pix", PIXEL_OUT, 0);
        chk("mid_rst_hs", HS_OUT, 1);
        chk("mid_rst_vs", VS_OUT, 1);
        chk("mid_rst_de", DE_OUT, 0);
        chk("mid_rst_vram_addr", VRAM_ADDR, 0);
        chk("mid_rst_font_addr", FONT_ADDR, 0);
        for (int i = 302; i < 306; i++) step(i, 200, 1, 1, 0);
        flush();
        frame(0, 0);
        for (int k = 1; k <= 32; k++) frame(k >= 32, 1);

        // randomized coordinates, memories, cursor, syncs and resets
        flush();
        for (int i = 0; i < 4096; i++) font[i] = 8'($urandom);
        for (int i = 0; i < 2400; i++) vram[i] = 8'($urandom);
        flush();
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                cen  = ($urandom_range(0, 3) != 0);
                ccol = $urandom_range(0, 79);
                crow = $urandom_range(0, 29);
            end
            r = $urandom_range(0, 9);
            if (r == 0) begin
                x = 0; y = 0;
            end else if (r <= 3) begin
                x = ccol * 8 + $urandom_range(0, 7);
                y = crow * 16 + $urandom_range(12, 15);
            end else begin
                x = $urandom_range(0, 799);
                y = $urandom_range(0, 524);
            end
            step(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 63) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_text_renderer.md
# vga_text_renderer

- Text-mode pixel generator fed directly by the VGA timing stage.
- Turns each screen coordinate into a monochrome pixel for an 80x30 character display with 8x16 glyphs:
  - fetches the character code from video RAM;
  - fetches the glyph row from the font ROM;
  - overlays a blinking underline cursor.
- Delays HS, VS and display-enable so they stay aligned with the 5-cycle pixel pipeline.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- BLINK_BIT, 5, frame-counter bit used as cursor blink phase (toggles every 2^BLINK_BIT frames)

Ports (one clock, `PIXEL_CLOCK`; reset is synchronous and active-high):
- PIXEL_CLOCK  in  1  pixel clock, all logic on rising edge
- RESET  in  1  synchronous active-high reset
- SCREEN_X  in  10  current pixel column from the timing stage
- SCREEN_Y  in  10  current line from the timing stage
- ON_SCREEN  in  1  visible flag; lags SCREEN_X/Y by one clock
- Hs  in  1  active-low hsync; lags SCREEN_X/Y by one clock
- Vs  in  1  active-low vsync; lags SCREEN_X/Y by one clock
- VRAM_ADDR  out  12  character address, row*80+col (0..2399)
- VRAM_DATA  in  8  character code; valid the cycle after the RAM samples VRAM_ADDR
- FONT_ADDR  out  12  {char[7:0], glyph_row[3:0]}
- FONT_DATA  in  8  glyph row bits, MSB = leftmost pixel; same latency as VRAM_DATA
- CURSOR_EN  in  1  cursor enable
- CURSOR_COL  in  7  cursor column 0..79
- CURSOR_ROW  in  5  cursor row 0..29
- PIXEL_OUT  out  1  pixel value, 0 when not on screen
- HS_OUT  out  1  delayed hsync, active low
- VS_OUT  out  1  delayed vsync, active low
- DE_OUT  out  1  delayed display enable

## Operation
- col = SCREEN_X[9:3], row = SCREEN_Y[9:4].
- row*80 is computed as (row<<6)+(row<<4); no multiplier.
- When SCREEN_X >= H_ACTIVE or SCREEN_Y >= V_ACTIVE, VRAM_ADDR is driven to 0, so it never exceeds 2399.
- Per-pixel side data travels alongside the fetch pipeline:
  - x[2:0] and y[3:0];
  - cursor hit = CURSOR_EN && col==CURSOR_COL && row==CURSOR_ROW && y[3:0]>=14.
- The cursor inputs are sampled in the same cycle as SCREEN_X/Y.
- FONT_ADDR = {VRAM_DATA, delayed y[3:0]}.
- Pixel = (FONT_DATA[7 - delayed x[2:0]] | (cursor_hit & blink)) & delayed DE.
- Frame counter: 6 bits.
  - Increments at the edge ending the cycle in which SCREEN_X==0 && SCREEN_Y==0.
  - Wraps 63 -> 0.
  - blink = FRAME_CNT[BLINK_BIT].
- HS_OUT, VS_OUT and DE_OUT are the Hs, Vs and ON_SCREEN inputs passed through a 4-stage shift register.
- Reset values:
  - VRAM_ADDR=0, FONT_ADDR=0, PIXEL_OUT=0;
  - HS_OUT=1, VS_OUT=1, DE_OUT=0;
  - frame counter=0;
  - every pipeline and sync-delay stage cleared to its inactive value (syncs 1, DE 0, cursor hit 0).
- Consequence: no spurious sync pulse for the 4 cycles after RESET falls.
- RESET asserted mid-frame: all outputs reach reset values at the next edge. The pipeline refills from the live inputs; no frame resynchronisation is needed.

## Timing
Cycle n = the cycle in which SCREEN_X/Y = (x,y) is presented.
- Edge 1 (end of n): VRAM_ADDR registered; stable during n+1.
- Edge 2: RAM samples the address; VRAM_DATA valid during n+2.
- Edge 3: FONT_ADDR registered; stable during n+3.
- Edge 4: ROM samples the address; FONT_DATA valid during n+4.
- Edge 5: PIXEL_OUT registered; the pixel for (x,y) is on PIXEL_OUT during n+5.
- The Hs/Vs/ON_SCREEN belonging to (x,y) arrive in n+1. After 4 delay stages they are on HS_OUT/VS_OUT/DE_OUT in n+5, aligned with PIXEL_OUT.
- Throughput: one pixel per clock, no stalls, no handshake.
- A frame-counter increment takes effect on the blink of pixel (0,0) of the same frame, because the cursor hit is combined with blink at edge 5.

## Test plan
- Reset alignment: hold RESET 3 cycles, release at X=0,Y=0 -> HS_OUT=VS_OUT=1, DE_OUT=0, PIXEL_OUT=0 for cycles 1-4; first visible pixel in cycle 5.
- Address generation: X=639,Y=479 -> VRAM_ADDR=2399 one cycle later; X=8,Y=16 -> 81; X=700 or Y=500 -> 0.
- Glyph fetch: VRAM model returns 0x41 at address 81, font model returns 0xA5 at {0x41,4'd3}; scan Y=19, X=8..15 -> FONT_ADDR=0x413; PIXEL_OUT sequence 1,0,1,0,0,1,0,1 starting 5 cycles after X=8.
- Sync alignment: Hs low input for X=656..751 (one-cycle lag) -> HS_OUT low exactly 4 cycles later, 96 cycles wide; DE_OUT falls in the same cycle the last visible pixel leaves PIXEL_OUT.
- Cursor blink: CURSOR_EN=1, COL=5, ROW=2, blank glyphs, BLINK_BIT=5:
  - frames 0-31 -> no cursor pixels;
  - frames 32-63 -> PIXEL_OUT=1 for X=40..47, Y=46..47 only;
  - frame 64 -> off again.
- Mid-frame reset: assert RESET at X=300,Y=200 for 1 cycle -> next edge gives reset values; the frame counter is cleared, so the cursor does not show again until 32 frames after reset.
